// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared loader state type and word geometry
package instr_mem_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream valid/ready channel feeding the loader
//   byte_valid/byte_data/byte_last: source -> loader
//   byte_ready: loader -> source
interface instr_mem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;
  modport master(output byte_valid, byte_data, byte_last, input byte_ready);
  modport slave(input byte_valid, byte_data, byte_last, output byte_ready);
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// instr_mem_loader_byte_packer: packs accepted bytes little-endian into 32-bit words
//   clr_i: drop any partial word; hs_i: byte accepted this cycle
//   data_i/last_i: accepted byte and end-of-image flag
//   word_o: buffer merged with the current byte; word_valid_o: this handshake closes a word
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic                          hs_i,
  input  logic                          last_i,
  input  logic [7:0]                    data_i,
  output logic [8*BYTES_PER_WORD-1:0]   word_o,
  output logic                          word_valid_o
);
  logic [1:0]                  idx_q, idx_d;
  logic [8*BYTES_PER_WORD-1:0] buf_q, buf_d;
  // Lanes at and above idx_q are always zero, so OR-ing the new byte in is enough
  // and a short final word comes out zero-filled.
  always_comb begin
    word_o       = buf_q | ((8*BYTES_PER_WORD)'(data_i) << {idx_q, 3'b000});
    word_valid_o = hs_i & (idx_q == 2'd3 | last_i);
    idx_d        = clr_i | word_valid_o ? 2'd0 : hs_i ? idx_q + 2'd1 : idx_q;
    buf_d        = clr_i | word_valid_o ? '0 : hs_i ? word_o : buf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams a byte image into instruction memory as 32-bit word writes
//   start_i: begin a session; s_i: byte stream (slave side)
//   wr_en_o/wr_addr_o/din_o: one-cycle write into the instruction memory
//   cpu_hold_o: keep the CPU in reset; done_o/overflow_o/word_count_o: session status
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024,
  localparam int                   CW         = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  instr_mem_loader_if.slave     s_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [CW-1:0]         word_count_o
);
  loader_state_t         state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [CW-1:0]         word_count_q, word_count_d;
  logic                  hs, clr, wv, full;
  logic [DATA_WIDTH-1:0] word;
  assign hs  = s_i.byte_valid & (state_q == LOAD);
  assign clr = start_i & (state_q != LOAD);
  instr_mem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .hs_i         (hs),
    .last_i       (s_i.byte_last),
    .data_i       (s_i.byte_data),
    .word_o       (word),
    .word_valid_o (wv)
  );
  always_comb begin
    full         = word_count_q == CW'(MAX_WORDS);
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    din_d        = din_q;
    word_count_d = word_count_q;
    if (clr) begin
      state_d      = LOAD;
      word_count_d = '0;
    end else if (wv & full) begin
      state_d = ERROR;
    end else if (wv) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = BASE_ADDR + (ADDR_WIDTH'(word_count_q) << 2);
      din_d        = word;
      word_count_d = word_count_q + CW'(1);
      state_d      = s_i.byte_last ? DONE : LOAD;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      din_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      din_q        <= din_d;
      word_count_q <= word_count_d;
    end
  assign s_i.byte_ready = state_q == LOAD;
  assign cpu_hold_o     = state_q == LOAD | state_q == ERROR;
  assign done_o         = state_q == DONE;
  assign overflow_o     = state_q == ERROR;
  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign din_o          = din_q;
  assign word_count_o   = word_count_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of the loader with default and small-capacity instances
module tb_instr_mem_loader;
  logic clk = 0, rst = 1, start1 = 0, start2 = 0, bv = 0, bl = 0, sel = 0;
  logic [7:0] bd = 0;
  int ncmp = 0, nerr = 0, stalls = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  instr_mem_loader_if m1();
  instr_mem_loader_if m2();
  assign m1.byte_valid = bv;
  assign m1.byte_data  = bd;
  assign m1.byte_last  = bl;
  assign m2.byte_valid = bv;
  assign m2.byte_data  = bd;
  assign m2.byte_last  = bl;

  logic        wr_en1, hold1, done1, ovf1, wr_en2, hold2, done2, ovf2;
  logic [31:0] addr1, din1, addr2, din2;
  logic [10:0] wc1;
  logic [1:0]  wc2;

  instr_mem_loader dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .s_i(m1.slave),
    .wr_en_o(wr_en1), .wr_addr_o(addr1), .din_o(din1), .cpu_hold_o(hold1),
    .done_o(done1), .overflow_o(ovf1), .word_count_o(wc1)
  );
  instr_mem_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .s_i(m2.slave),
    .wr_en_o(wr_en2), .wr_addr_o(addr2), .din_o(din2), .cpu_hold_o(hold2),
    .done_o(done2), .overflow_o(ovf2), .word_count_o(wc2)
  );

  logic [31:0] qa1[$], qd1[$], qa2[$], qd2[$];
  int qc1[$];
  always @(negedge clk) begin
    if (wr_en1) begin
      qa1.push_back(addr1);
      qd1.push_back(din1);
      qc1.push_back(cyc);
    end
    if (wr_en2) begin
      qa2.push_back(addr2);
      qd2.push_back(din2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    bv = 1; bd = d; bl = l;
    while (!(sel ? m2.byte_ready : m1.byte_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    stalls += n;
    if (n == 20) begin
      nerr++;
      $error("FAIL ready_wait: observed no byte_ready after %0d cycles expected ready", n);
    end
    @(posedge clk); #1;
    bv = 0; bl = 0;
  endtask

  task automatic go(input logic which);
    sel = which;
    if (which) start2 = 1; else start1 = 1;
    @(posedge clk); #1;
    start1 = 0; start2 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clrq;
    qa1.delete(); qd1.delete(); qc1.delete(); qa2.delete(); qd2.delete();
  endtask

  initial begin
    #1;
    chk("rst_ready", 32'(m1.byte_ready), 0);
    chk("rst_wr_en", 32'(wr_en1), 0);
    chk("rst_addr", addr1, 0);
    chk("rst_din", din1, 0);
    chk("rst_status", {28'd0, hold1, done1, ovf1, 1'b0}, 0);
    chk("rst_wc", 32'(wc1), 0);
    idle(2);
    rst = 0;

    // single word, last on lane 3
    go(0);
    chk("t1_ready", 32'(m1.byte_ready), 1);
    chk("t1_hold_load", 32'(hold1), 1);
    send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 1);
    chk("t1_wr_en", 32'(wr_en1), 1);
    chk("t1_addr", addr1, 32'h0);
    chk("t1_din", din1, 32'h00100513);
    chk("t1_wc", 32'(wc1), 1);
    chk("t1_done", 32'(done1), 1);
    chk("t1_hold_done", 32'(hold1), 0);
    idle(1);
    chk("t1_wr_en_pulse", 32'(wr_en1), 0);
    chk("t1_nwrites", 32'(qa1.size()), 1);

    // two back-to-back words
    clrq(); stalls = 0;
    go(0);
    chk("t2_done_clr", 32'(done1), 0);
    chk("t2_wc_clr", 32'(wc1), 0);
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    idle(1);
    chk("t2_nwrites", 32'(qa1.size()), 2);
    chk("t2_addr0", qa1[0], 32'h0);
    chk("t2_din0", qd1[0], 32'h04030201);
    chk("t2_addr1", qa1[1], 32'h4);
    chk("t2_din1", qd1[1], 32'h08070605);
    chk("t2_spacing", 32'(qc1[1] - qc1[0]), 4);
    chk("t2_no_stall", 32'(stalls), 0);
    chk("t2_wc", 32'(wc1), 2);

    // short final word
    clrq();
    go(0);
    for (int i = 0; i < 6; i++) send(8'hAA + 8'(i), i == 5);
    idle(1);
    chk("t3_nwrites", 32'(qa1.size()), 2);
    chk("t3_din0", qd1[0], 32'hADACABAA);
    chk("t3_addr1", qa1[1], 32'h4);
    chk("t3_din1", qd1[1], 32'h0000AFAE);
    chk("t3_wc", 32'(wc1), 2);

    // overflow on the small instance; dut1 sits in DONE and must ignore the stream
    clrq();
    go(1);
    chk("t4_ready", 32'(m2.byte_ready), 1);
    chk("t4_wc_start", 32'(wc2), 0);
    for (int i = 0; i < 12; i++) send(8'h20 + 8'(i), 0);
    chk("t4_overflow", 32'(ovf2), 1);
    chk("t4_ready_err", 32'(m2.byte_ready), 0);
    chk("t4_hold_err", 32'(hold2), 1);
    chk("t4_done_err", 32'(done2), 0);
    chk("t4_wc", 32'(wc2), 2);
    idle(1);
    chk("t4_nwrites", 32'(qa2.size()), 2);
    chk("t4_addr0", qa2[0], 32'h100);
    chk("t4_din0", qd2[0], 32'h23222120);
    chk("t4_addr1", qa2[1], 32'h104);
    chk("t4_din1", qd2[1], 32'h27262524);
    chk("t4_dut1_untouched", 32'(qa1.size()), 0);
    chk("t4_dut1_wc", 32'(wc1), 2);
    go(1);
    chk("t4_ovf_clr", 32'(ovf2), 0);
    chk("t4_wc_clr", 32'(wc2), 0);
    chk("t4_ready_again", 32'(m2.byte_ready), 1);

    // gaps in byte_valid
    clrq();
    go(0);
    for (int i = 0; i < 8; i++) begin
      send(8'h11 + 8'(i), i == 7);
      idle(i % 3);
    end
    idle(1);
    chk("t5_nwrites", 32'(qa1.size()), 2);
    chk("t5_din0", qd1[0], 32'h14131211);
    chk("t5_addr1", qa1[1], 32'h4);
    chk("t5_din1", qd1[1], 32'h18171615);

    // asynchronous reset mid-word, then reload with a lane-0 last byte
    clrq();
    go(0);
    send(8'h55, 0); send(8'h66, 0);
    #2 rst = 1;
    #1;
    chk("t6_ready", 32'(m1.byte_ready), 0);
    chk("t6_hold", 32'(hold1), 0);
    chk("t6_addr", addr1, 0);
    chk("t6_din", din1, 0);
    chk("t6_wc", 32'(wc1), 0);
    @(posedge clk); #1;
    rst = 0;
    go(0);
    send(8'h9A, 1);
    chk("t6_wr_en", 32'(wr_en1), 1);
    chk("t6_addr_base", addr1, 32'h0);
    chk("t6_din_lane0", din1, 32'h0000009A);
    chk("t6_wc_after", 32'(wc1), 1);
    idle(1);
    chk("t6_nwrites", 32'(qa1.size()), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
